// File: rtl/multimode_ff_bank.sv
`default_nettype none
// ============================================================================
//  Module   : multimode_ff_bank
//  Function : WIDTH-bit flip-flop bank, per-cycle D/T/JK/SR mode, with
//             parallel load, clock enable, change mask, saturating activity
//             counter and sticky illegal-SR flag.
//  Revision : 1.0  initial release
// ============================================================================
module multimode_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter int               CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_err,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic [WIDTH-1:0] changed,
    output logic [CNT_W-1:0] act_cnt,
    output logic             sr_err
);

    localparam logic [1:0]       c_MODE_D  = 2'b00;
    localparam logic [1:0]       c_MODE_T  = 2'b01;
    localparam logic [1:0]       c_MODE_JK = 2'b10;
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_changed;
    logic [CNT_W-1:0] r_act_cnt;
    logic             r_sr_err;

    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_diff;
    logic             w_sr_set;

    // Per-bit next state; SR with S=R=1 holds the bit (a^b == 0 keeps q).
    always_comb begin
        w_q_next = r_q;
        w_sr_set = 1'b0;
        if (load) begin
            w_q_next = load_val;
        end else if (en) begin
            case (mode)
                c_MODE_D:  w_q_next = a;
                c_MODE_T:  w_q_next = r_q ^ a;
                c_MODE_JK: w_q_next = (a & ~r_q) | (~b & r_q);
                default: begin
                    w_q_next = (r_q & ~(a ^ b)) | (a & ~b);
                    w_sr_set = |(a & b);
                end
            endcase
        end
    end

    assign w_diff = w_q_next ^ r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q       <= RST_VAL;
            r_changed <= '0;
            r_act_cnt <= '0;
            r_sr_err  <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_changed <= w_diff;
            if ((|w_diff) && (r_act_cnt != c_CNT_MAX)) begin
                r_act_cnt <= r_act_cnt + c_CNT_ONE;
            end
            // Set takes priority over clear on the same edge.
            if (w_sr_set) begin
                r_sr_err <= 1'b1;
            end else if (clr_err) begin
                r_sr_err <= 1'b0;
            end
        end
    end

    assign q       = r_q;
    assign qbar    = ~r_q;
    assign changed = r_changed;
    assign act_cnt = r_act_cnt;
    assign sr_err  = r_sr_err;

endmodule
`default_nettype wire

// File: tb/tb_multimode_ff_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multimode_ff_bank
//  Function : directed self-checking bench for multimode_ff_bank
//  Revision : 1.0  initial release
// ============================================================================
module tb_multimode_ff_bank;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] a;
    logic [7:0] b;
    logic       load;
    logic [7:0] load_val;
    logic       clr_err;
    logic [7:0] q;
    logic [7:0] qbar;
    logic [7:0] changed;
    logic [3:0] act_cnt;
    logic       sr_err;

    int n_cmp = 0;
    int n_err = 0;

    multimode_ff_bank #(
        .WIDTH  (8),
        .RST_VAL(8'h00),
        .CNT_W  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .mode    (mode),
        .a       (a),
        .b       (b),
        .load    (load),
        .load_val(load_val),
        .clr_err (clr_err),
        .q       (q),
        .qbar    (qbar),
        .changed (changed),
        .act_cnt (act_cnt),
        .sr_err  (sr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; mode = 2'b01; a = 8'hFF; b = 8'hFF;
        load = 1'b1; load_val = 8'hFF; clr_err = 1'b0;
        #2;
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL rst_q q=%h expected 00", q); end
        n_cmp++; if (qbar !== 8'hFF) begin n_err++; $display("FAIL rst_qbar qbar=%h expected FF", qbar); end
        n_cmp++; if (changed !== 8'h00) begin n_err++; $display("FAIL rst_changed changed=%h expected 00", changed); end
        n_cmp++; if (act_cnt !== 4'h0) begin n_err++; $display("FAIL rst_act act_cnt=%h expected 0", act_cnt); end
        n_cmp++; if (sr_err !== 1'b0) begin n_err++; $display("FAIL rst_err sr_err=%b expected 0", sr_err); end
        load = 1'b0; en = 1'b0;
        rst = 1'b1;
        step();
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL rst_hold q=%h expected 00", q); end
    endtask

    task automatic test_t_mode();
        logic [7:0] exp_q [3];
        exp_q[0] = 8'h81; exp_q[1] = 8'h00; exp_q[2] = 8'h81;
        en = 1'b1; mode = 2'b01; a = 8'h81; b = 8'h00;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (q !== exp_q[i]) begin n_err++; $display("FAIL t_q[%0d] q=%h expected %h", i, q, exp_q[i]); end
            n_cmp++; if (changed !== 8'h81) begin n_err++; $display("FAIL t_changed[%0d] changed=%h expected 81", i, changed); end
            n_cmp++; if (act_cnt !== 4'(i + 1)) begin n_err++; $display("FAIL t_act[%0d] act_cnt=%h expected %h", i, act_cnt, 4'(i + 1)); end
        end
    endtask

    task automatic test_jk_mode();
        load = 1'b1; load_val = 8'hF0;
        step();
        n_cmp++; if (q !== 8'hF0) begin n_err++; $display("FAIL jk_load q=%h expected F0", q); end
        // F0 with J=CC K=AA: bits7,3 toggle; 6,2 set; 5,1 clear; 4,0 hold -> 5C
        load = 1'b0; en = 1'b1; mode = 2'b10; a = 8'hCC; b = 8'hAA;
        step();
        n_cmp++; if (q !== 8'h5C) begin n_err++; $display("FAIL jk_q q=%h expected 5C", q); end
        n_cmp++; if (qbar !== 8'hA3) begin n_err++; $display("FAIL jk_qbar qbar=%h expected A3", qbar); end
        n_cmp++; if (changed !== 8'hAC) begin n_err++; $display("FAIL jk_changed changed=%h expected AC", changed); end
        n_cmp++; if (act_cnt !== 4'd5) begin n_err++; $display("FAIL jk_act act_cnt=%h expected 5", act_cnt); end
    endtask

    task automatic test_sr_mode();
        load = 1'b1; load_val = 8'h0F;
        step();
        load = 1'b0; en = 1'b1; mode = 2'b11; a = 8'h03; b = 8'h01;
        step();
        n_cmp++; if (q !== 8'h0F) begin n_err++; $display("FAIL sr_ill_q q=%h expected 0F", q); end
        n_cmp++; if (sr_err !== 1'b1) begin n_err++; $display("FAIL sr_ill_err sr_err=%b expected 1", sr_err); end
        n_cmp++; if (act_cnt !== 4'd6) begin n_err++; $display("FAIL sr_ill_act act_cnt=%h expected 6", act_cnt); end
        a = 8'h30; b = 8'h03;
        step();
        n_cmp++; if (q !== 8'h3C) begin n_err++; $display("FAIL sr_q q=%h expected 3C", q); end
        n_cmp++; if (changed !== 8'h33) begin n_err++; $display("FAIL sr_changed changed=%h expected 33", changed); end
        n_cmp++; if (sr_err !== 1'b1) begin n_err++; $display("FAIL sr_sticky sr_err=%b expected 1", sr_err); end
        a = 8'h00; b = 8'h00; clr_err = 1'b1;
        step();
        n_cmp++; if (sr_err !== 1'b0) begin n_err++; $display("FAIL sr_clr sr_err=%b expected 0", sr_err); end
        n_cmp++; if (q !== 8'h3C) begin n_err++; $display("FAIL sr_hold q=%h expected 3C", q); end
        a = 8'h01; b = 8'h01;
        step();
        n_cmp++; if (sr_err !== 1'b1) begin n_err++; $display("FAIL sr_set_wins sr_err=%b expected 1", sr_err); end
        n_cmp++; if (q !== 8'h3C) begin n_err++; $display("FAIL sr_set_wins_q q=%h expected 3C", q); end
        clr_err = 1'b0;
    endtask

    task automatic test_priority();
        en = 1'b0; load = 1'b0; mode = 2'b01; a = 8'hFF;
        step();
        n_cmp++; if (q !== 8'h3C) begin n_err++; $display("FAIL pri_en_q q=%h expected 3C", q); end
        n_cmp++; if (changed !== 8'h00) begin n_err++; $display("FAIL pri_en_changed changed=%h expected 00", changed); end
        n_cmp++; if (act_cnt !== 4'd7) begin n_err++; $display("FAIL pri_en_act act_cnt=%h expected 7", act_cnt); end
        load = 1'b1; load_val = 8'h5A;
        step();
        n_cmp++; if (q !== 8'h5A) begin n_err++; $display("FAIL pri_load_q q=%h expected 5A", q); end
        n_cmp++; if (changed !== 8'h66) begin n_err++; $display("FAIL pri_load_changed changed=%h expected 66", changed); end
        en = 1'b1; mode = 2'b00;
        step();
        n_cmp++; if (q !== 8'h5A) begin n_err++; $display("FAIL pri_same_q q=%h expected 5A", q); end
        n_cmp++; if (changed !== 8'h00) begin n_err++; $display("FAIL pri_same_changed changed=%h expected 00", changed); end
        n_cmp++; if (act_cnt !== 4'd8) begin n_err++; $display("FAIL pri_same_act act_cnt=%h expected 8", act_cnt); end
    endtask

    task automatic test_saturation_async_reset();
        logic [3:0] exp_cnt;
        load = 1'b0; en = 1'b1; mode = 2'b01; a = 8'hFF;
        for (int i = 1; i <= 20; i++) begin
            step();
            exp_cnt = (8 + i > 15) ? 4'hF : 4'(8 + i);
            n_cmp++; if (act_cnt !== exp_cnt) begin n_err++; $display("FAIL sat_act[%0d] act_cnt=%h expected %h", i, act_cnt, exp_cnt); end
        end
        n_cmp++; if (q !== 8'h5A) begin n_err++; $display("FAIL sat_q q=%h expected 5A", q); end
        load = 1'b1; load_val = 8'hA5; en = 1'b0;
        #3 rst = 1'b0;
        #1;
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL arst_q q=%h expected 00", q); end
        n_cmp++; if (act_cnt !== 4'h0) begin n_err++; $display("FAIL arst_act act_cnt=%h expected 0", act_cnt); end
        n_cmp++; if (sr_err !== 1'b0) begin n_err++; $display("FAIL arst_err sr_err=%b expected 0", sr_err); end
        #2 rst = 1'b1;
        step();
        n_cmp++; if (q !== 8'hA5) begin n_err++; $display("FAIL arst_load_q q=%h expected A5", q); end
        n_cmp++; if (changed !== 8'hA5) begin n_err++; $display("FAIL arst_load_changed changed=%h expected A5", changed); end
        n_cmp++; if (act_cnt !== 4'd1) begin n_err++; $display("FAIL arst_load_act act_cnt=%h expected 1", act_cnt); end
    endtask

    initial begin
        test_reset();
        test_t_mode();
        test_jk_mode();
        test_sr_mode();
        test_priority();
        test_saturation_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
